// File: rtl/pspin_egress_cmd_queue_if.sv
// Handshake bundle between PsPIN HPUs, the egress command queue and the
// egress DMA engine.
//
// Valid/ready semantics: a transfer on nic_cmd_req or m_desc happens on a
// rising clk edge where valid && ready are both 1; the source holds its
// payload stable while valid && !ready and never withdraws valid early.
// s_status and nic_cmd_resp have no ready: each valid is a one-cycle pulse
// that the sink must take.
//
// Modports:
//   master - environment side: drives commands, DMA ready and DMA status
//   slave  - queue side: accepts commands, issues descriptors, responds
interface pspin_egress_cmd_queue_if #(
    parameter int AXI_HOST_ADDR_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int CMD_ID_WIDTH        = 6
);
    // NIC command request
    logic                           nic_cmd_req_ready;
    logic                           nic_cmd_req_valid;
    logic [CMD_ID_WIDTH-1:0]        nic_cmd_req_id;
    logic [31:0]                    nic_cmd_req_nid;
    logic [31:0]                    nic_cmd_req_fid;
    logic [AXI_HOST_ADDR_WIDTH-1:0] nic_cmd_req_src_addr;
    logic [AXI_ADDR_WIDTH-1:0]      nic_cmd_req_length;
    logic [63:0]                    nic_cmd_req_user_ptr;

    // Read descriptor to egress DMA
    logic [AXI_ADDR_WIDTH-1:0]      m_desc_addr;
    logic [AXI_ADDR_WIDTH-1:0]      m_desc_len;
    logic [CMD_ID_WIDTH-1:0]        m_desc_tag;
    logic                           m_desc_valid;
    logic                           m_desc_ready;

    // DMA completion status
    logic [CMD_ID_WIDTH-1:0]        s_status_tag;
    logic [3:0]                     s_status_error;
    logic                           s_status_valid;

    // NIC command response
    logic                           nic_cmd_resp_valid;
    logic [CMD_ID_WIDTH-1:0]        nic_cmd_resp_id;
    logic [3:0]                     nic_cmd_resp_error;

    modport master (
        input  nic_cmd_req_ready,
        output nic_cmd_req_valid, nic_cmd_req_id, nic_cmd_req_nid,
               nic_cmd_req_fid, nic_cmd_req_src_addr, nic_cmd_req_length,
               nic_cmd_req_user_ptr,
        input  m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
        output m_desc_ready,
        output s_status_tag, s_status_error, s_status_valid,
        input  nic_cmd_resp_valid, nic_cmd_resp_id, nic_cmd_resp_error
    );

    modport slave (
        output nic_cmd_req_ready,
        input  nic_cmd_req_valid, nic_cmd_req_id, nic_cmd_req_nid,
               nic_cmd_req_fid, nic_cmd_req_src_addr, nic_cmd_req_length,
               nic_cmd_req_user_ptr,
        output m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
        input  m_desc_ready,
        input  s_status_tag, s_status_error, s_status_valid,
        output nic_cmd_resp_valid, nic_cmd_resp_id, nic_cmd_resp_error
    );
endinterface

// File: rtl/pspin_egress_cmd_queue.sv
// Egress command queue: in-order FIFO of NIC commands from PsPIN HPUs.
// Legal head commands become DMA read descriptors (bounded number in flight);
// illegal ones are completed locally with an error code. DMA status and
// local completions are merged onto the single response channel.
//
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset (release is
//                        expected to be synchronous to clk)
//   bus (slave)        - command request, descriptor, DMA status, response
//   outstanding_count  - descriptors handed to the DMA and not yet completed
//   fifo_level         - entries waiting in the command FIFO
//   reject_count       - saturating count of locally rejected commands
module pspin_egress_cmd_queue #(
    parameter int AXI_HOST_ADDR_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int CMD_ID_WIDTH        = 6,
    parameter int DEPTH               = 16,
    parameter int MAX_OUTSTANDING     = 8,
    parameter int MAX_LEN             = 9216
) (
    input  logic                       clk,
    input  logic                       rstn,
    pspin_egress_cmd_queue_if.slave    bus,
    output logic [7:0]                 outstanding_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [31:0]                reject_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [3:0] ERR_ZERO_LEN = 4'hE;
    localparam logic [3:0] ERR_TOO_LONG = 4'hD;
    localparam logic [3:0] ERR_ADDR_HI  = 4'hC;
    localparam logic [3:0] ERR_NONE     = 4'h0;

    typedef struct packed {
        logic [CMD_ID_WIDTH-1:0]        id;
        logic [AXI_HOST_ADDR_WIDTH-1:0] addr;
        logic [AXI_ADDR_WIDTH-1:0]      len;
    } cmd_t;

    // ---------------- command FIFO ----------------
    cmd_t           mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  count_q, count_d;

    cmd_t           in_cmd;
    cmd_t           head;
    logic           fifo_empty;
    logic           push;
    logic           head_valid;
    logic [3:0]     head_err;
    logic           legal_pop;
    logic           illegal_pop;
    logic           bypass;
    logic           mem_write;
    logic           fifo_pop;

    // ---------------- descriptor register ----------------
    logic                       desc_valid_q, desc_valid_d;
    logic [AXI_ADDR_WIDTH-1:0]  desc_addr_q, desc_addr_d;
    logic [AXI_ADDR_WIDTH-1:0]  desc_len_q, desc_len_d;
    logic [CMD_ID_WIDTH-1:0]    desc_tag_q, desc_tag_d;
    logic                       desc_hs;
    logic                       desc_free;
    logic                       inflight_ok;

    // ---------------- local completion + response ----------------
    logic                       lc_valid_q, lc_valid_d;
    logic [CMD_ID_WIDTH-1:0]    lc_id_q, lc_id_d;
    logic [3:0]                 lc_err_q, lc_err_d;
    logic                       resp_valid_q, resp_valid_d;
    logic [CMD_ID_WIDTH-1:0]    resp_id_q, resp_id_d;
    logic [3:0]                 resp_err_q, resp_err_d;

    logic [7:0]                 out_cnt_q, out_cnt_d;
    logic [31:0]                rej_cnt_q, rej_cnt_d;

    // nid, fid and user_ptr travel with the command but are not needed here.
    logic unused_req_fields;
    assign unused_req_fields = ^{bus.nic_cmd_req_nid, bus.nic_cmd_req_fid,
                                 bus.nic_cmd_req_user_ptr};

    assign in_cmd     = '{id:   bus.nic_cmd_req_id,
                          addr: bus.nic_cmd_req_src_addr,
                          len:  bus.nic_cmd_req_length};
    assign fifo_empty = (count_q == '0);
    assign bus.nic_cmd_req_ready = (count_q != LW'(DEPTH));
    assign push       = bus.nic_cmd_req_valid && bus.nic_cmd_req_ready;

    // An empty FIFO presents the incoming command as its head, so a command
    // arriving at an idle queue reaches the descriptor register one cycle
    // after acceptance instead of two.
    assign head_valid = !fifo_empty || push;
    assign head       = fifo_empty ? in_cmd : mem_q[rd_ptr_q];

    always_comb begin
        head_err = ERR_NONE;
        if (head.len == '0) begin
            head_err = ERR_ZERO_LEN;
        end else if (32'(head.len) > 32'(MAX_LEN)) begin
            head_err = ERR_TOO_LONG;
        end else if (head.addr[AXI_HOST_ADDR_WIDTH-1:AXI_ADDR_WIDTH] != '0) begin
            head_err = ERR_ADDR_HI;
        end
    end

    assign desc_hs   = desc_valid_q && bus.m_desc_ready;
    assign desc_free = !desc_valid_q || bus.m_desc_ready;
    // A descriptor sitting in the register counts as in flight, which keeps
    // the limit safe even before the DMA takes it.
    assign inflight_ok = ({1'b0, out_cnt_q} + {8'd0, desc_valid_q}) < 9'(MAX_OUTSTANDING);

    assign legal_pop   = head_valid && (head_err == ERR_NONE) && desc_free && inflight_ok;
    assign illegal_pop = head_valid && (head_err != ERR_NONE) && !lc_valid_q;

    assign bypass    = fifo_empty && push && (legal_pop || illegal_pop);
    assign mem_write = push && !bypass;
    assign fifo_pop  = (legal_pop || illegal_pop) && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(mem_write);
        rd_ptr_d = rd_ptr_q + PW'(fifo_pop);
        count_d  = count_q + LW'(mem_write) - LW'(fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem_q[wr_ptr_q] <= in_cmd;
        end
    end

    // Descriptor register: loads on a legal pop, otherwise empties on handshake.
    always_comb begin
        desc_valid_d = desc_valid_q;
        desc_addr_d  = desc_addr_q;
        desc_len_d   = desc_len_q;
        desc_tag_d   = desc_tag_q;
        if (legal_pop) begin
            desc_valid_d = 1'b1;
            desc_addr_d  = head.addr[AXI_ADDR_WIDTH-1:0];
            desc_len_d   = head.len;
            desc_tag_d   = head.id;
        end else if (desc_hs) begin
            desc_valid_d = 1'b0;
        end
    end

    // Local completion holds one rejected command until the response channel
    // is free of DMA status.
    always_comb begin
        lc_valid_d = lc_valid_q;
        lc_id_d    = lc_id_q;
        lc_err_d   = lc_err_q;
        if (illegal_pop) begin
            lc_valid_d = 1'b1;
            lc_id_d    = head.id;
            lc_err_d   = head_err;
        end else if (lc_valid_q && !bus.s_status_valid) begin
            lc_valid_d = 1'b0;
        end
    end

    always_comb begin
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        if (bus.s_status_valid) begin
            resp_valid_d = 1'b1;
            resp_id_d    = bus.s_status_tag;
            resp_err_d   = bus.s_status_error;
        end else if (lc_valid_q) begin
            resp_valid_d = 1'b1;
            resp_id_d    = lc_id_q;
            resp_err_d   = lc_err_q;
        end
    end

    // A status at count 0 cannot decrement; a status coinciding with an issue
    // leaves the count where it was.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (desc_hs && !bus.s_status_valid) begin
            out_cnt_d = out_cnt_q + 8'd1;
        end else if (!desc_hs && bus.s_status_valid && (out_cnt_q != 8'd0)) begin
            out_cnt_d = out_cnt_q - 8'd1;
        end
        rej_cnt_d = rej_cnt_q;
        if (illegal_pop && (rej_cnt_q != 32'hFFFF_FFFF)) begin
            rej_cnt_d = rej_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            desc_valid_q <= 1'b0;
            desc_addr_q  <= '0;
            desc_len_q   <= '0;
            desc_tag_q   <= '0;
            lc_valid_q   <= 1'b0;
            lc_id_q      <= '0;
            lc_err_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_err_q   <= '0;
            out_cnt_q    <= '0;
            rej_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            desc_valid_q <= desc_valid_d;
            desc_addr_q  <= desc_addr_d;
            desc_len_q   <= desc_len_d;
            desc_tag_q   <= desc_tag_d;
            lc_valid_q   <= lc_valid_d;
            lc_id_q      <= lc_id_d;
            lc_err_q     <= lc_err_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            out_cnt_q    <= out_cnt_d;
            rej_cnt_q    <= rej_cnt_d;
        end
    end

    assign bus.m_desc_valid       = desc_valid_q;
    assign bus.m_desc_addr        = desc_addr_q;
    assign bus.m_desc_len         = desc_len_q;
    assign bus.m_desc_tag         = desc_tag_q;
    assign bus.nic_cmd_resp_valid = resp_valid_q;
    assign bus.nic_cmd_resp_id    = resp_id_q;
    assign bus.nic_cmd_resp_error = resp_err_q;
    assign outstanding_count      = out_cnt_q;
    assign fifo_level             = count_q;
    assign reject_count           = rej_cnt_q;
endmodule
